// File: rtl/dp_ram_sync_pkg.sv
// dp_ram_sync_pkg
// Purpose: constants and types shared by the dual-port RAM slice.
//   RD_FIRST / WR_FIRST / NO_CHANGE select what a port returns when it
//   writes; state_t is the clear-sequencer state.
// Ports: none (package).
package dp_ram_sync_pkg;

  localparam int RD_FIRST  = 0;
  localparam int WR_FIRST  = 1;
  localparam int NO_CHANGE = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/dp_ram_sync_if.sv
// dp_ram_sync_if
// Purpose: one RAM access port (request plus response).
// Signals: en, we, be, addr, data_in (master -> RAM);
//          data_out, valid (RAM -> master).
// Modports: master (requester side), slave (RAM side).
interface dp_ram_sync_if #(
  parameter int DATA  = 32,
  parameter int LANE  = 8,
  parameter int DEPTH = 16
);
  localparam int LANES = DATA / LANE;
  localparam int ADDR  = $clog2(DEPTH);

  logic             en;
  logic             we;
  logic [LANES-1:0] be;
  logic [ADDR-1:0]  addr;
  logic [DATA-1:0]  data_in;
  logic [DATA-1:0]  data_out;
  logic             valid;

  modport master (output en, we, be, addr, data_in, input data_out, valid);
  modport slave  (input en, we, be, addr, data_in, output data_out, valid);

endinterface

// File: rtl/dp_ram_sync_port.sv
// dp_ram_port
// Purpose: per-port response path: read-mode mux, optional output register
//   and valid pipeline.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   i_ld      an access producing a response was accepted this cycle
//   i_wr      that access was a write
//   i_be      its lane enables
//   i_din     its write data
//   i_old     registered array word (pre-write contents), valid after i_ld
//   o_data    response data, holds when o_valid is low
//   o_valid   one-cycle pulse per response
module dp_ram_port
  import dp_ram_sync_pkg::*;
#(
  parameter int DATA    = 32,
  parameter int LANE    = 8,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0,
  localparam int LANES  = DATA / LANE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ld,
  input  logic             i_wr,
  input  logic [LANES-1:0] i_be,
  input  logic [DATA-1:0]  i_din,
  input  logic [DATA-1:0]  i_old,
  output logic [DATA-1:0]  o_data,
  output logic             o_valid
);

  logic             r_vld_s1;
  logic             r_wr_s1;
  logic [LANES-1:0] r_be_s1;
  logic [DATA-1:0]  r_din_s1;
  logic [DATA-1:0]  w_merged;
  logic [DATA-1:0]  w_word;

  // Request attributes load only with a response so that the unregistered
  // output stays stable between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_s1 <= 1'b0;
      r_wr_s1  <= 1'b0;
      r_be_s1  <= '0;
      r_din_s1 <= '0;
    end else begin
      r_vld_s1 <= i_ld;
      if (i_ld) begin
        r_wr_s1  <= i_wr;
        r_be_s1  <= i_be;
        r_din_s1 <= i_din;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_merge
    assign w_merged[gi*LANE +: LANE] = r_be_s1[gi] ? r_din_s1[gi*LANE +: LANE]
                                                   : i_old[gi*LANE +: LANE];
  end

  // Write-first shows this port's own merge; reads always see the old word.
  assign w_word = ((RD_MODE == WR_FIRST) && r_wr_s1) ? w_merged : i_old;

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA-1:0] r_dout;
    logic            r_vld_s2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dout   <= '0;
        r_vld_s2 <= 1'b0;
      end else begin
        r_vld_s2 <= r_vld_s1;
        if (r_vld_s1) r_dout <= w_word;
      end
    end
    assign o_data  = r_dout;
    assign o_valid = r_vld_s2;
  end else begin : g_noreg
    assign o_data  = w_word;
    assign o_valid = r_vld_s1;
  end

endmodule

// File: rtl/dp_ram_sync.sv
// dp_ram_sync
// Purpose: single-clock true dual-port RAM with lane write enables,
//   selectable same-port read-during-write behaviour, optional output
//   register, A-wins collision resolution and a post-reset clear sequencer.
// Ports:
//   clk          rising-edge clock for both ports
//   rst          asynchronous active-high reset
//   o_init_done  array ready; port requests are discarded while low
//   o_collide    one-cycle pulse after both ports wrote overlapping lanes
//                of the same word
//   port_a/b     access ports (dp_ram_sync_if.slave)
module dp_ram_sync
  import dp_ram_sync_pkg::*;
#(
  parameter int DATA         = 32,
  parameter int LANE         = 8,
  parameter int DEPTH        = 16,
  parameter int RD_MODE      = 0,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic         clk,
  input  logic         rst,
  output logic         o_init_done,
  output logic         o_collide,
  dp_ram_sync_if.slave port_a,
  dp_ram_sync_if.slave port_b
);

  localparam int LANES = DATA / LANE;
  localparam int ADDR  = $clog2(DEPTH);
  localparam logic [ADDR:0]   DEPTH_W = (ADDR+1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST    = ADDR'(DEPTH - 1);

  state_t          r_state, w_state_next;
  logic [ADDR-1:0] r_cnt, w_cnt_next;
  logic            r_init_done;
  logic            r_collide;
  logic            w_clr_we;

  // Clear FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_init_done <= (r_state == ST_READY);
    end
  end

  // Clear FSM: next state, one word zeroed per cycle
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_next = ST_READY;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    w_clr_we = (r_state == ST_CLEAR);
  end

  // Access decode. init_done is low for the whole of CLEAR, so port writes
  // never contend with the clear write.
  logic w_acc_a, w_acc_b, w_wr_a, w_wr_b, w_ld_a, w_ld_b, w_same, w_collide;
  assign w_acc_a   = r_init_done & port_a.en & ({1'b0, port_a.addr} < DEPTH_W);
  assign w_acc_b   = r_init_done & port_b.en & ({1'b0, port_b.addr} < DEPTH_W);
  assign w_wr_a    = w_acc_a & port_a.we;
  assign w_wr_b    = w_acc_b & port_b.we;
  assign w_ld_a    = w_acc_a & ~(port_a.we & (RD_MODE == NO_CHANGE));
  assign w_ld_b    = w_acc_b & ~(port_b.we & (RD_MODE == NO_CHANGE));
  assign w_same    = (port_a.addr == port_b.addr);
  assign w_collide = w_wr_a & w_wr_b & w_same & (|(port_a.be & port_b.be));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_collide <= 1'b0;
    else     r_collide <= w_collide;
  end

  // One narrow array per lane keeps lane writes independent.
  logic [DATA-1:0] w_old_a, w_old_b;
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE-1:0] r_mem [DEPTH];
    logic [LANE-1:0] r_rd_a, r_rd_b;
    logic            w_we_a, w_we_b;

    assign w_we_a = w_wr_a & port_a.be[gi];
    // Port A owns a lane both ports write at the same address.
    assign w_we_b = w_wr_b & port_b.be[gi] & ~(w_we_a & w_same);

    always_ff @(posedge clk) begin
      if (w_clr_we) begin
        r_mem[r_cnt] <= '0;
      end else begin
        if (w_we_a) r_mem[port_a.addr] <= port_a.data_in[gi*LANE +: LANE];
        if (w_we_b) r_mem[port_b.addr] <= port_b.data_in[gi*LANE +: LANE];
      end
    end

    // Registered read captures pre-write contents, giving read-first and
    // old-data cross-port behaviour directly.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rd_a <= '0;
        r_rd_b <= '0;
      end else begin
        if (w_ld_a) r_rd_a <= r_mem[port_a.addr];
        if (w_ld_b) r_rd_b <= r_mem[port_b.addr];
      end
    end

    assign w_old_a[gi*LANE +: LANE] = r_rd_a;
    assign w_old_b[gi*LANE +: LANE] = r_rd_b;
  end

  logic [DATA-1:0] w_dout_a, w_dout_b;
  logic            w_valid_a, w_valid_b;

  dp_ram_port #(.DATA(DATA), .LANE(LANE), .RD_MODE(RD_MODE), .OUT_REG(OUT_REG)) u_port_a (
    .clk     (clk),
    .rst     (rst),
    .i_ld    (w_ld_a),
    .i_wr    (port_a.we),
    .i_be    (port_a.be),
    .i_din   (port_a.data_in),
    .i_old   (w_old_a),
    .o_data  (w_dout_a),
    .o_valid (w_valid_a)
  );

  dp_ram_port #(.DATA(DATA), .LANE(LANE), .RD_MODE(RD_MODE), .OUT_REG(OUT_REG)) u_port_b (
    .clk     (clk),
    .rst     (rst),
    .i_ld    (w_ld_b),
    .i_wr    (port_b.we),
    .i_be    (port_b.be),
    .i_din   (port_b.data_in),
    .i_old   (w_old_b),
    .o_data  (w_dout_b),
    .o_valid (w_valid_b)
  );

  assign port_a.data_out = w_dout_a;
  assign port_a.valid    = w_valid_a;
  assign port_b.data_out = w_dout_b;
  assign port_b.valid    = w_valid_b;
  assign o_init_done     = r_init_done;
  assign o_collide       = r_collide;

endmodule

// File: tb/tb_dp_ram_sync.sv
// tb_dp_ram_sync
// Purpose: directed self-checking bench for dp_ram_sync. Three instances
//   share one stimulus stream:
//   u0: read-first, no output register, DEPTH 16
//   u1: write-first, output register, DEPTH 16
//   u2: no-change, no output register, DEPTH 12 (exercises addr >= DEPTH)
module tb_dp_ram_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init0, init1, init2, col0, col1, col2;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   e0, e1, e2;
  logic any_v;

  always #5 clk = ~clk;

  dp_ram_sync_if #(.DATA(32), .LANE(8), .DEPTH(16)) a0 ();
  dp_ram_sync_if #(.DATA(32), .LANE(8), .DEPTH(16)) b0 ();
  dp_ram_sync_if #(.DATA(32), .LANE(8), .DEPTH(16)) a1 ();
  dp_ram_sync_if #(.DATA(32), .LANE(8), .DEPTH(16)) b1 ();
  dp_ram_sync_if #(.DATA(32), .LANE(8), .DEPTH(12)) a2 ();
  dp_ram_sync_if #(.DATA(32), .LANE(8), .DEPTH(12)) b2 ();

  dp_ram_sync #(.DEPTH(16), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) u0 (
    .clk(clk), .rst(rst), .o_init_done(init0), .o_collide(col0), .port_a(a0), .port_b(b0));
  dp_ram_sync #(.DEPTH(16), .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(1)) u1 (
    .clk(clk), .rst(rst), .o_init_done(init1), .o_collide(col1), .port_a(a1), .port_b(b1));
  dp_ram_sync #(.DEPTH(12), .RD_MODE(2), .OUT_REG(0), .CLEAR_ON_RST(1)) u2 (
    .clk(clk), .rst(rst), .o_init_done(init2), .o_collide(col2), .port_a(a2), .port_b(b2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic en, input logic we, input logic [3:0] be,
                       input logic [3:0] addr, input logic [31:0] din);
    a0.en = en; a0.we = we; a0.be = be; a0.addr = addr; a0.data_in = din;
    a1.en = en; a1.we = we; a1.be = be; a1.addr = addr; a1.data_in = din;
    a2.en = en; a2.we = we; a2.be = be; a2.addr = addr; a2.data_in = din;
  endtask

  task automatic drv_b(input logic en, input logic we, input logic [3:0] be,
                       input logic [3:0] addr, input logic [31:0] din);
    b0.en = en; b0.we = we; b0.be = be; b0.addr = addr; b0.data_in = din;
    b1.en = en; b1.we = we; b1.be = be; b1.addr = addr; b1.data_in = din;
    b2.en = en; b2.we = we; b2.be = be; b2.addr = addr; b2.data_in = din;
  endtask

  task automatic idle();
    drv_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    drv_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Counts edges after reset release until each init_done rises. The
  // requests driven on entry are dropped to idle at edge 10, before any
  // instance is ready.
  task automatic wait_init(output int r0, output int r1, output int r2, output logic v);
    r0 = 0; r1 = 0; r2 = 0; v = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (r0 == 0 && init0) r0 = e;
      if (r1 == 0 && init1) r1 = e;
      if (r2 == 0 && init2) r2 = e;
      v = v | a0.valid | b0.valid | a1.valid | b1.valid | a2.valid | b2.valid;
      if (e == 10) idle();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    // Reset state
    step(); step();
    chk("rst_init_done", init0, 1'b0);
    chk("rst_valid_a", a0.valid, 1'b0);
    chk("rst_valid_b1", b1.valid, 1'b0);
    chk("rst_dout_a", a0.data_out, 32'h0);
    chk("rst_dout_b1", b1.data_out, 32'h0);
    chk("rst_collide", col0, 1'b0);

    // Power-up clear, with requests presented while init_done is low
    drv_a(1'b1, 1'b1, 4'hF, 4'd0, 32'h00000BAD);
    drv_b(1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
    rst = 1'b0;
    wait_init(e0, e1, e2, any_v);
    chk("init_edge_u0", e0, 17);
    chk("init_edge_u1", e1, 17);
    chk("init_edge_u2", e2, 13);
    chk("no_valid_while_clearing", any_v, 1'b0);

    // Byte enables
    drv_a(1'b1, 1'b1, 4'hF, 4'd3, 32'h11223344); step();
    drv_a(1'b1, 1'b1, 4'b0101, 4'd3, 32'hAABBCCDD); step();
    drv_a(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    drv_b(1'b1, 1'b0, 4'h0, 4'd3, 32'h0); step();
    chk("be_u0_valid_b", b0.valid, 1'b1);
    chk("be_u0_data_b", b0.data_out, 32'h11BB33DD);
    chk("be_u2_data_b", b2.data_out, 32'h11BB33DD);
    chk("be_u1_valid_b_early", b1.valid, 1'b0);
    idle(); step();
    chk("be_u1_valid_b", b1.valid, 1'b1);
    chk("be_u1_data_b", b1.data_out, 32'h11BB33DD);
    chk("be_u0_valid_b_pulse", b0.valid, 1'b0);
    chk("be_u0_data_b_hold", b0.data_out, 32'h11BB33DD);

    // Read-during-write on port A (mem[5] is zero)
    drv_a(1'b1, 1'b0, 4'h0, 4'd3, 32'h0); step();
    chk("rdw_pre_u2_data_a", a2.data_out, 32'h11BB33DD);
    drv_a(1'b1, 1'b1, 4'hF, 4'd5, 32'h5); step();
    chk("rdw_u0_valid_a", a0.valid, 1'b1);
    chk("rdw_u0_readfirst", a0.data_out, 32'h0);
    chk("rdw_u2_no_valid", a2.valid, 1'b0);
    chk("rdw_u2_hold", a2.data_out, 32'h11BB33DD);
    chk("rdw_u1_prev_read", a1.data_out, 32'h11BB33DD);
    idle(); step();
    chk("rdw_u1_valid_a", a1.valid, 1'b1);
    chk("rdw_u1_writefirst", a1.data_out, 32'h5);
    chk("rdw_u0_pulse", a0.valid, 1'b0);
    chk("rdw_u2_still_no_valid", a2.valid, 1'b0);

    // Write collision at addr 7
    drv_a(1'b1, 1'b1, 4'b1100, 4'd7, 32'hAAAAAAAA);
    drv_b(1'b1, 1'b1, 4'b0110, 4'd7, 32'hBBBBBBBB); step();
    chk("col_u0_pulse", col0, 1'b1);
    chk("col_u2_pulse", col2, 1'b1);
    idle(); step();
    chk("col_u0_drop", col0, 1'b0);
    drv_b(1'b1, 1'b0, 4'h0, 4'd7, 32'h0); step();
    chk("col_u0_word", b0.data_out, 32'hAAAABB00);
    idle(); step();
    chk("col_u1_word", b1.data_out, 32'hAAAABB00);

    // Cross-port read during write
    drv_a(1'b1, 1'b1, 4'hF, 4'd2, 32'h1); step();
    drv_a(1'b1, 1'b1, 4'hF, 4'd2, 32'h9);
    drv_b(1'b1, 1'b0, 4'h0, 4'd2, 32'h0); step();
    chk("xp_u0_old", b0.data_out, 32'h1);
    chk("xp_u2_old", b2.data_out, 32'h1);
    idle(); step();
    chk("xp_u1_old", b1.data_out, 32'h1);
    drv_b(1'b1, 1'b0, 4'h0, 4'd2, 32'h0); step();
    chk("xp_u0_new", b0.data_out, 32'h9);
    idle(); step();
    chk("xp_u1_new", b1.data_out, 32'h9);

    // Address beyond DEPTH on the 12-word instance
    drv_b(1'b1, 1'b0, 4'h0, 4'd13, 32'h0); step();
    chk("oob_u2_no_valid", b2.valid, 1'b0);
    chk("oob_u2_hold", b2.data_out, 32'h9);
    chk("oob_u0_valid", b0.valid, 1'b1);
    chk("oob_u0_data", b0.data_out, 32'h0);
    idle(); step();

    // Fill with non-zero data, then back-to-back reads
    for (int i = 0; i < 16; i++) begin
      drv_a(1'b1, 1'b1, 4'hF, 4'(i), 32'hDEAD0000 | 32'(i)); step();
    end
    idle();
    drv_b(1'b1, 1'b0, 4'h0, 4'd8, 32'h0); step();
    chk("b2b_u0_v0", b0.valid, 1'b1);
    chk("b2b_u0_d0", b0.data_out, 32'hDEAD0008);
    drv_b(1'b1, 1'b0, 4'h0, 4'd9, 32'h0); step();
    chk("b2b_u0_v1", b0.valid, 1'b1);
    chk("b2b_u0_d1", b0.data_out, 32'hDEAD0009);
    chk("b2b_u1_d0", b1.data_out, 32'hDEAD0008);
    drv_b(1'b1, 1'b0, 4'h0, 4'd10, 32'h0); step();
    chk("b2b_u0_d2", b0.data_out, 32'hDEAD000A);
    chk("b2b_u1_v1", b1.valid, 1'b1);
    chk("b2b_u1_d1", b1.data_out, 32'hDEAD0009);
    idle(); step();
    chk("b2b_u0_end", b0.valid, 1'b0);
    chk("b2b_u0_hold", b0.data_out, 32'hDEAD000A);
    step();

    // Reset mid-clear: release, let 8 words clear, reset again
    rst = 1'b1; step();
    chk("rst2_init_done", init0, 1'b0);
    chk("rst2_dout_b", b0.data_out, 32'h0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; step();
    chk("rst3_init_done", init0, 1'b0);
    drv_a(1'b1, 1'b1, 4'hF, 4'd0, 32'h00000BAD);
    drv_b(1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
    rst = 1'b0;
    wait_init(e0, e1, e2, any_v);
    chk("restart_edge_u0", e0, 17);
    chk("restart_edge_u2", e2, 13);
    chk("restart_no_valid", any_v, 1'b0);

    // Every word cleared, including those written while init_done was low
    for (int i = 0; i < 16; i++) begin
      drv_b(1'b1, 1'b0, 4'h0, 4'(i), 32'h0); step();
      chk($sformatf("clr_valid_%0d", i), b0.valid, 1'b1);
      chk($sformatf("clr_data_%0d", i), b0.data_out, 32'h0);
      idle(); step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
